// File: rtl/logicgates_pkg.sv
// logicgates_pkg: shared types for the gate truth-table checker.
// Gate select encoding, FSM states and vector bookkeeping widths.
package logicgates_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_NAND = 3'd4,
    GATE_XOR  = 3'd5,
    GATE_XNOR = 3'd6,
    GATE_RSVD = 3'd7
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE_PULSE
  } state_e;

  function automatic logic sel_is_rsvd(
    input logic [2:0] sel
  );
    return sel == GATE_RSVD;
  endfunction

endpackage

// File: rtl/logicgates_truth_table_checker_if.sv
// Control/result bundle of the truth-table checker.
// master issues start/gate_sel; slave (the checker) reports status.
interface logicgates_truth_table_checker_if;

  logic       start;
  logic [2:0] gate_sel;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic       err_sel;

  modport master (
    output start,
    output gate_sel,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  err_sel
  );

  modport slave (
    input  start,
    input  gate_sel,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output err_sel
  );

endinterface

// File: rtl/logicgates_ref_model.sv
// Reference truth table for the 2-input gate library.
// Purely combinational; also usable as a bench scoreboard.
module logicgates_ref_model
  import logicgates_pkg::*;
(
  input  gate_sel_e sel,
  input  logic      a,
  input  logic      b,
  output logic      y_exp
);

  // Expected gate output for the selected gate type
  always_comb begin
    y_exp = 1'b0;
    unique case (1'b1)
      (sel == GATE_AND):  y_exp = a & b;
      (sel == GATE_OR):   y_exp = a | b;
      (sel == GATE_NOT):  y_exp = ~a;
      (sel == GATE_NOR):  y_exp = ~(a | b);
      (sel == GATE_NAND): y_exp = ~(a & b);
      (sel == GATE_XOR):  y_exp = a ^ b;
      (sel == GATE_XNOR): y_exp = ~(a ^ b);
      default:            y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/logicgates_truth_table_checker.sv
// Exhaustive sequential tester for one 2-input gate instance.
// Walks a,b through 00..11, samples y after a settle window.
module logicgates_truth_table_checker
  import logicgates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  logicgates_truth_table_checker_if.slave ctl,
  output logic a,
  output logic b,
  input  logic y
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST =
    VEC_W'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  gate_sel_e              sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [NUM_VECTORS-1:0] mask_q, mask_d;
  logic                   err_q, err_d;

  logic                   y_exp;
  logic                   vec_miss;
  logic                   last_tick;
  logic                   last_vec;
  logic [VEC_W-1:0]       vec_inc;
  logic [NUM_VECTORS-1:0] mask_upd;

  logicgates_ref_model u_ref (
    .sel   (sel_q),
    .a     (a_q),
    .b     (b_q),
    .y_exp (y_exp)
  );

  assign last_tick = cnt_q == CNT_LAST;
  assign last_vec  = vec_q == VEC_LAST;
  assign vec_miss  = y != y_exp;
  assign vec_inc   = vec_q + VEC_W'(1);
  assign mask_upd  = mask_q
    | (NUM_VECTORS'(vec_miss) << vec_q);

  // Next-state and next-output decode for the run FSM
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE_PULSE: begin
        state_d = ST_IDLE;
        if (ctl.start) begin
          if (sel_is_rsvd(ctl.gate_sel)) begin
            state_d = ST_DONE_PULSE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            pass_d  = 1'b0;
            mask_d  = '1;
          end else begin
            state_d = ST_SETTLE;
            sel_d   = gate_sel_e'(ctl.gate_sel);
            cnt_d   = '0;
            vec_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            mask_d  = '0;
            err_d   = 1'b0;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_tick) begin
          cnt_d  = '0;
          mask_d = mask_upd;
          if (last_vec) begin
            state_d = ST_DONE_PULSE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = mask_upd == '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            vec_d = vec_inc;
            a_d   = vec_inc[1];
            b_d   = vec_inc[0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset clears every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= GATE_AND;
      cnt_q   <= '0;
      vec_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign a             = a_q;
  assign b             = b_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.fail_mask = mask_q;
  assign ctl.err_sel   = err_q;

endmodule

// File: tb/tb_logicgates_truth_table_checker.sv
// Directed bench for the gate truth-table checker.
// dut0 uses SETTLE_CYCLES=2, dut1 uses SETTLE_CYCLES=1.
module tb_logicgates_truth_table_checker;

  logic clk;
  logic rst_n;
  logic a0, b0, y0;
  logic a1, b1, y1;
  int   y_mode;
  int   errors;
  int   checks;

  logicgates_truth_table_checker_if c0 ();
  logicgates_truth_table_checker_if c1 ();

  logicgates_truth_table_checker #(
    .SETTLE_CYCLES (2)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (c0),
    .a     (a0),
    .b     (b0),
    .y     (y0)
  );

  logicgates_truth_table_checker #(
    .SETTLE_CYCLES (1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (c1),
    .a     (a1),
    .b     (b1),
    .y     (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate stand-in for dut0, selectable good/faulty behaviour
  always_comb begin
    y0 = 1'b0;
    case (y_mode)
      0: y0 = a0 & b0;
      1: y0 = a0 ^ b0;
      2: y0 = ~a0;
      default: y0 = 1'b0;
    endcase
  end

  // Correct OR gate for dut1
  always_comb y1 = a1 | b1;

  // Runs one dut0 test and records its trace (no checks here)
  task automatic run0(
    input  logic [2:0]  sel,
    output int          nbusy,
    output logic        got_done,
    output logic        busy_at_done,
    output logic        done_after,
    output logic [15:0] ab_seq
  );
    nbusy = 0;
    got_done = 1'b0;
    busy_at_done = 1'b1;
    ab_seq = '0;
    @(negedge clk);
    c0.start = 1'b1;
    c0.gate_sel = sel;
    @(negedge clk);
    c0.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (c0.done) begin
        got_done = 1'b1;
        busy_at_done = c0.busy;
        break;
      end
      if (c0.busy) begin
        nbusy++;
        ab_seq = {ab_seq[13:0], a0, b0};
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = c0.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a0, b0, c0.busy, c0.done, c0.pass,
         c0.err_sel} !== 6'b0) begin
      errors++;
      $display("FAIL reset_bits0: got %b want 000000",
        {a0, b0, c0.busy, c0.done, c0.pass, c0.err_sel});
    end
    checks++;
    if (c0.fail_mask !== 4'h0) begin
      errors++;
      $display("FAIL reset_mask0: got %h want 0",
        c0.fail_mask);
    end
    checks++;
    if ({a1, b1, c1.busy, c1.done, c1.pass, c1.err_sel,
         c1.fail_mask} !== 10'b0) begin
      errors++;
      $display("FAIL reset_dut1: got %b want 0",
        {a1, b1, c1.busy, c1.done, c1.pass, c1.err_sel,
         c1.fail_mask});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and_pass();
    int n;
    logic gd, bd, da;
    logic [15:0] ab;
    y_mode = 0;
    run0(3'd0, n, gd, bd, da, ab);
    checks++;
    if (gd !== 1'b1) begin
      errors++;
      $display("FAIL and_done: got %b want 1", gd);
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL and_busy_len: got %0d want 8", n);
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++;
      $display("FAIL and_busy_at_done: got %b want 0", bd);
    end
    checks++;
    if (da !== 1'b0) begin
      errors++;
      $display("FAIL and_done_width: got %b want 0", da);
    end
    checks++;
    if (ab !== 16'h05AF) begin
      errors++;
      $display("FAIL and_ab_seq: got %h want 05af", ab);
    end
    checks++;
    if (c0.pass !== 1'b1) begin
      errors++;
      $display("FAIL and_pass: got %b want 1", c0.pass);
    end
    checks++;
    if (c0.fail_mask !== 4'b0000) begin
      errors++;
      $display("FAIL and_mask: got %b want 0000",
        c0.fail_mask);
    end
    checks++;
    if (c0.err_sel !== 1'b0) begin
      errors++;
      $display("FAIL and_err_sel: got %b want 0",
        c0.err_sel);
    end
  endtask

  task automatic test_nand_fault();
    int n;
    logic gd, bd, da;
    logic [15:0] ab;
    y_mode = 1;
    run0(3'd4, n, gd, bd, da, ab);
    checks++;
    if (gd !== 1'b1) begin
      errors++;
      $display("FAIL nand_done: got %b want 1", gd);
    end
    checks++;
    if (c0.pass !== 1'b0) begin
      errors++;
      $display("FAIL nand_pass: got %b want 0", c0.pass);
    end
    checks++;
    if (c0.fail_mask !== 4'b0001) begin
      errors++;
      $display("FAIL nand_mask: got %b want 0001",
        c0.fail_mask);
    end
  endtask

  task automatic test_not();
    int n;
    logic gd, bd, da;
    logic [15:0] ab;
    y_mode = 2;
    run0(3'd2, n, gd, bd, da, ab);
    checks++;
    if ({c0.pass, c0.fail_mask} !== 5'b1_0000) begin
      errors++;
      $display("FAIL not_good: got %b want 10000",
        {c0.pass, c0.fail_mask});
    end
    y_mode = 3;
    run0(3'd2, n, gd, bd, da, ab);
    checks++;
    if (c0.pass !== 1'b0) begin
      errors++;
      $display("FAIL not_stuck_pass: got %b want 0",
        c0.pass);
    end
    checks++;
    if (c0.fail_mask !== 4'b0011) begin
      errors++;
      $display("FAIL not_stuck_mask: got %b want 0011",
        c0.fail_mask);
    end
  endtask

  task automatic test_reserved();
    @(negedge clk);
    c0.start = 1'b1;
    c0.gate_sel = 3'd7;
    @(negedge clk);
    c0.start = 1'b0;
    checks++;
    if ({c0.done, c0.err_sel, c0.pass} !== 3'b110) begin
      errors++;
      $display("FAIL rsvd_flags: got %b want 110",
        {c0.done, c0.err_sel, c0.pass});
    end
    checks++;
    if (c0.fail_mask !== 4'hF) begin
      errors++;
      $display("FAIL rsvd_mask: got %h want f",
        c0.fail_mask);
    end
    checks++;
    if ({c0.busy, a0, b0} !== 3'b000) begin
      errors++;
      $display("FAIL rsvd_idle: got %b want 000",
        {c0.busy, a0, b0});
    end
    @(negedge clk);
    checks++;
    if ({c0.done, c0.busy, c0.err_sel} !== 3'b001) begin
      errors++;
      $display("FAIL rsvd_after: got %b want 001",
        {c0.done, c0.busy, c0.err_sel});
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int ndone;
    logic hit;
    logic gd, bd, da;
    logic [15:0] ab;
    y_mode = 1;
    hit = 1'b0;
    ndone = 0;
    @(negedge clk);
    c0.start = 1'b1;
    c0.gate_sel = 3'd5;
    @(negedge clk);
    c0.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (c0.busy && a0 && !b0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hit !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_vec2: got %b want 1", hit);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, b0, c0.busy, c0.done, c0.pass, c0.err_sel,
         c0.fail_mask} !== 10'b0) begin
      errors++;
      $display("FAIL abort_async_clear: got %b want 0",
        {a0, b0, c0.busy, c0.done, c0.pass, c0.err_sel,
         c0.fail_mask});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c0.done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (c0.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d want 0", ndone);
    end
    run0(3'd5, n, gd, bd, da, ab);
    checks++;
    if ({gd, c0.pass, c0.fail_mask} !== 6'b11_0000) begin
      errors++;
      $display("FAIL xor_after_abort: got %b want 110000",
        {gd, c0.pass, c0.fail_mask});
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL xor_busy_len: got %0d want 8", n);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    logic gd;
    y_mode = 0;
    gd = 1'b0;
    @(negedge clk);
    c0.start = 1'b1;
    c0.gate_sel = 3'd0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (c0.done) begin
        gd = 1'b1;
        break;
      end
    end
    checks++;
    if ({gd, c0.busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first_done: got %b want 10",
        {gd, c0.busy});
    end
    @(negedge clk);
    c0.start = 1'b0;
    checks++;
    if ({c0.busy, c0.done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_relaunch: got %b want 10",
        {c0.busy, c0.done});
    end
    nb = 1;
    gd = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (c0.done) begin
        gd = 1'b1;
        break;
      end
      if (c0.busy) nb++;
    end
    checks++;
    if ({gd, c0.pass} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_second: got %b want 11",
        {gd, c0.pass});
    end
    checks++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL b2b_busy_len: got %0d want 8", nb);
    end
    @(negedge clk);
  endtask

  task automatic test_settle_one();
    int nb;
    logic gd;
    logic [7:0] ab;
    nb = 0;
    gd = 1'b0;
    ab = '0;
    @(negedge clk);
    c1.start = 1'b1;
    c1.gate_sel = 3'd1;
    @(negedge clk);
    c1.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (c1.done) begin
        gd = 1'b1;
        break;
      end
      if (c1.busy) begin
        nb++;
        ab = {ab[5:0], a1, b1};
      end
      @(negedge clk);
    end
    checks++;
    if ({gd, c1.pass, c1.fail_mask} !== 6'b11_0000) begin
      errors++;
      $display("FAIL s1_result: got %b want 110000",
        {gd, c1.pass, c1.fail_mask});
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL s1_busy_len: got %0d want 4", nb);
    end
    checks++;
    if (ab !== 8'h1B) begin
      errors++;
      $display("FAIL s1_ab_seq: got %h want 1b", ab);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int nb;
    logic gd;
    nb = 0;
    gd = 1'b0;
    @(negedge clk);
    c1.start = 1'b1;
    c1.gate_sel = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (c1.done) begin
        gd = 1'b1;
        break;
      end
      if (c1.busy) nb++;
      if (i == 1) begin
        c1.start = 1'b1;
        c1.gate_sel = 3'd1;
      end else begin
        c1.start = 1'b0;
      end
      @(negedge clk);
    end
    c1.start = 1'b0;
    checks++;
    if ({gd, c1.pass} !== 2'b10) begin
      errors++;
      $display("FAIL busy_ign_result: got %b want 10",
        {gd, c1.pass});
    end
    checks++;
    if (c1.fail_mask !== 4'b0110) begin
      errors++;
      $display("FAIL busy_ign_mask: got %b want 0110",
        c1.fail_mask);
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL busy_ign_len: got %0d want 4", nb);
    end
    @(negedge clk);
    checks++;
    if ({c1.busy, c1.done} !== 2'b00) begin
      errors++;
      $display("FAIL busy_ign_no_rerun: got %b want 00",
        {c1.busy, c1.done});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    y_mode = 0;
    rst_n = 1'b0;
    c0.start = 1'b0;
    c0.gate_sel = 3'd0;
    c1.start = 1'b0;
    c1.gate_sel = 3'd0;
    test_reset();
    test_and_pass();
    test_nand_fault();
    test_not();
    test_reserved();
    test_reset_mid_run();
    test_back_to_back();
    test_settle_one();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
